// File: rtl/clint_timer_swi.sv
// clint_timer_swi: core-local interruptor with 64-bit mtime/mtimecmp timer (IRQ7) and msip (IRQ3).
// Defining CLINT_MTIME_WRITE_EN makes the mtime halves bus-writable.
module clint_timer_swi #(
  parameter int DIV = 1,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              IRQ3,
  output logic              IRQ7,
  output logic [63:0]       mtime
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre;
  logic [63:0] mtimecmp;
  logic msip;
  logic [31:0] rdata_q, rd_val;
  logic [ADDR_W-1:0] a;
  logic take, wr, tick;
  logic sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i+:8] = d[8*i+:8];
    return r;
  endfunction
  always_comb begin
    a          = addr & ~ADDR_W'(3);
    sel_msip   = a == ADDR_W'(32'h0000);
    sel_cmp_lo = a == ADDR_W'(32'h4000);
    sel_cmp_hi = a == ADDR_W'(32'h4004);
    sel_mt_lo  = a == ADDR_W'(32'hBFF8);
    sel_mt_hi  = a == ADDR_W'(32'hBFFC);
    take       = state == IDLE && valid;
    wr         = take && |wstrb;
    state_n    = take ? ACK : IDLE;
    tick       = pre == PW'(DIV - 1);
    rd_val     = sel_msip   ? {31'b0, msip}   :
                 sel_cmp_lo ? mtimecmp[31:0]  :
                 sel_cmp_hi ? mtimecmp[63:32] :
                 sel_mt_lo  ? mtime[31:0]     :
                 sel_mt_hi  ? mtime[63:32]    : 32'b0;
  end
  assign ready = state == ACK;
  assign rdata = ready ? rdata_q : 32'b0;
  assign IRQ3  = msip;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre      <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      msip     <= 1'b0;
      rdata_q  <= '0;
      IRQ7     <= 1'b0;
    end else begin
      pre  <= tick ? '0 : pre + PW'(1);
      IRQ7 <= mtime >= mtimecmp;
      if (take) rdata_q <= wr ? 32'b0 : rd_val;
      if (wr && sel_msip && wstrb[0]) msip <= wdata[0];
      if (wr && sel_cmp_lo) mtimecmp[31:0] <= merge(mtimecmp[31:0], wstrb, wdata);
      if (wr && sel_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], wstrb, wdata);
`ifdef CLINT_MTIME_WRITE_EN
      // A write to either half suppresses that cycle's tick entirely, so no carry crosses halves.
      if (wr && sel_mt_lo) mtime[31:0] <= merge(mtime[31:0], wstrb, wdata);
      else if (wr && sel_mt_hi) mtime[63:32] <= merge(mtime[63:32], wstrb, wdata);
      else if (tick) mtime <= mtime + 64'd1;
`else
      if (tick) mtime <= mtime + 64'd1;
`endif
    end
  end
endmodule

// File: tb/tb_clint_timer_swi.sv
// tb_clint_timer_swi: directed bus stimulus checked every cycle against a behavioural CLINT model.
module tb_clint_timer_swi;
  localparam int DIV = 1;
  logic clk = 1'b0, reset = 1'b1, valid = 1'b0;
  logic [15:0] addr = '0;
  logic [3:0] wstrb = '0;
  logic [31:0] wdata = '0;
  logic ready, irq3, irq7;
  logic [31:0] rdata;
  logic [63:0] mtime;
  logic ready4, irq34, irq74;
  logic [31:0] rdata4;
  logic [63:0] mtime4;
  int checks = 0, errors = 0;
  bit armed = 1'b0;
  always #5 clk = ~clk;
  clint_timer_swi #(.DIV(DIV), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .rdata(rdata), .IRQ3(irq3), .IRQ7(irq7), .mtime(mtime));
  clint_timer_swi #(.DIV(4), .ADDR_W(16)) dut4 (
    .clk(clk), .reset(reset), .valid(1'b0), .ready(ready4), .addr(16'h0), .wstrb(4'h0),
    .wdata(32'h0), .rdata(rdata4), .IRQ3(irq34), .IRQ7(irq74), .mtime(mtime4));
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // Behavioural model: timer as a tick count, registers as plain values, bus as one-deep handshake.
  logic [63:0] m_mt, m_cmp;
  logic [31:0] m_rdata;
  bit m_msip, m_irq7, m_ready, m_rdchk;
  longint cyc, cyc4;
  function automatic logic [31:0] bmask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
  function automatic logic [31:0] upd(input logic [31:0] old, input logic [3:0] be, input logic [31:0] d);
    return (old & ~bmask(be)) | (d & bmask(be));
  endfunction
  function automatic logic [31:0] mrd(input logic [15:0] a);
    case ({a[15:2], 2'b00})
      16'h0000: return {31'b0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mt[31:0];
      16'hBFFC: return m_mt[63:32];
      default:  return 32'h0;
    endcase
  endfunction
  always @(posedge clk) begin : model
    bit take, wr, drop;
    if (reset) begin
      m_mt = 0; m_cmp = '1; m_msip = 0; m_irq7 = 0; m_ready = 0; m_rdchk = 0; m_rdata = 0;
      cyc = 0; cyc4 = 0;
    end else begin
      take = valid && !m_ready;
      wr = take && wstrb != 0;
      drop = 0;
      m_irq7 = m_mt >= m_cmp;
      m_rdchk = take && !wr;
      m_rdata = mrd(addr);
      m_ready = take;
      if (wr)
        case ({addr[15:2], 2'b00})
          16'h0000: if (wstrb[0]) m_msip = wdata[0];
          16'h4000: m_cmp[31:0] = upd(m_cmp[31:0], wstrb, wdata);
          16'h4004: m_cmp[63:32] = upd(m_cmp[63:32], wstrb, wdata);
`ifdef CLINT_MTIME_WRITE_EN
          16'hBFF8: begin m_mt[31:0] = upd(m_mt[31:0], wstrb, wdata); drop = 1; end
          16'hBFFC: begin m_mt[63:32] = upd(m_mt[63:32], wstrb, wdata); drop = 1; end
`endif
          default: ;
        endcase
      if (cyc % DIV == DIV - 1 && !drop) m_mt = m_mt + 1;
      cyc++;
      cyc4++;
    end
  end
  always @(negedge clk) if (armed) begin
    chk("mtime", mtime, m_mt);
    chk("irq3", irq3, m_msip);
    chk("irq7", irq7, m_irq7);
    chk("ready", ready, m_ready);
    if (!m_ready) chk("rdata_idle", rdata, 0);
    else if (m_rdchk) chk("rdata", rdata, m_rdata);
    chk("mtime_div4", mtime4, cyc4 / 4);
  end
  task automatic bus(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    valid = 1; addr = a; wstrb = be; wdata = d;
    @(negedge clk);
    valid = 0; wstrb = 0;
    chk("ack", ready, 1);
    r = rdata;
  endtask
  task automatic do_reset();
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
  endtask
  initial begin
    logic [31:0] r;
    logic [63:0] t0;
    repeat (2) @(negedge clk);
    reset = 0;
    armed = 1;
    chk("t1_mtime", mtime, 0);
    chk("t1_irq3", irq3, 0);
    chk("t1_irq7", irq7, 0);
    chk("t1_ready", ready, 0);
    bus(16'h4004, 4'h0, 32'h0, r);
    chk("t1_cmp_hi", r, 32'hFFFF_FFFF);
    do_reset();
    repeat (40) @(negedge clk);
    chk("t2_div1", mtime, 40);
    chk("t2_div4", mtime4, 10);
    bus(16'h4000, 4'b0010, 32'h0000_AB00, r);
    bus(16'h4000, 4'h0, 32'h0, r);
    chk("t6_strobe", r, 32'hFFFF_ABFF);
    bus(16'h1000, 4'h0, 32'h0, r);
    chk("t6_unmapped", r, 0);
    do_reset();
    bus(16'h4004, 4'hF, 32'h0, r);
    bus(16'h4000, 4'hF, 32'h20, r);
    for (int i = 0; i < 100 && mtime != 64'h20; i++) @(negedge clk);
    chk("t3_reach", mtime, 64'h20);
    chk("t3_irq7_lag", irq7, 0);
    @(negedge clk);
    chk("t3_irq7_rise", irq7, 1);
    bus(16'h4000, 4'hF, 32'hFFFF_FFFF, r);
    chk("t3_irq7_hold", irq7, 1);
    @(negedge clk);
    chk("t3_irq7_fall", irq7, 0);
    bus(16'h0000, 4'hF, 32'hFFFF_FFFF, r);
    chk("t4_irq3_set", irq3, 1);
    bus(16'h0000, 4'h0, 32'h0, r);
    chk("t4_msip_rd", r, 1);
    bus(16'h0000, 4'hF, 32'h0, r);
    chk("t4_irq3_clr", irq3, 0);
    t0 = mtime;
    bus(16'hBFFC, 4'hF, 32'h0, r);
    bus(16'hBFF8, 4'hF, 32'hFFFF_FFFF, r);
`ifdef CLINT_MTIME_WRITE_EN
    chk("t5_written", mtime, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    chk("t5_carry", mtime, 64'h1_0000_0000);
`else
    chk("t5_readonly", mtime, t0 + 4);
`endif
    @(negedge clk);
    valid = 1; addr = 16'h0; wstrb = 4'hF; wdata = 32'h1; reset = 1;
    @(negedge clk);
    valid = 0; wstrb = 0; reset = 0;
    chk("rst_mid_ready", ready, 0);
    chk("rst_mid_irq3", irq3, 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
